// File: rtl/button_events.sv
// Turns a debounced button level into one-cycle press / release / long-press / repeat strobes.
// Hold time is counted in clken ticks; edges are detected at full clock rate.
module button_events #(
    parameter int WIDTH        = 10,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       in,
    output logic       press,
    output logic       release_strobe,
    output logic       long_press,
    output logic       repeat_strobe,
    output logic       held,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LONG_LAST   = WIDTH'(LONG_TICKS - 1);
    localparam logic [WIDTH-1:0] REPEAT_LAST = WIDTH'(REPEAT_TICKS - 1);

    state_t           state;
    logic             prev;
    logic [WIDTH-1:0] counter;

    assign dbg_state = state;

    // Strobes default low every cycle; a release always wins over a tick in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            prev           <= 1'b0;
            counter        <= '0;
            press          <= 1'b0;
            release_strobe <= 1'b0;
            long_press     <= 1'b0;
            repeat_strobe  <= 1'b0;
            held           <= 1'b0;
        end else begin
            prev           <= in;
            press          <= 1'b0;
            release_strobe <= 1'b0;
            long_press     <= 1'b0;
            repeat_strobe  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in && !prev) begin
                        state   <= ST_PRESSED;
                        counter <= '0;
                        press   <= 1'b1;
                        held    <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!in) begin
                        state          <= ST_IDLE;
                        release_strobe <= 1'b1;
                        held           <= 1'b0;
                    end else if (clken) begin
                        if (counter == LONG_LAST) begin
                            state      <= ST_REPEAT;
                            counter    <= '0;
                            long_press <= 1'b1;
                        end else begin
                            counter <= counter + WIDTH'(1);
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!in) begin
                        state          <= ST_IDLE;
                        release_strobe <= 1'b1;
                        held           <= 1'b0;
                    end else if (clken) begin
                        if (counter == REPEAT_LAST) begin
                            counter       <= '0;
                            repeat_strobe <= 1'b1;
                        end else begin
                            counter <= counter + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule
